io_port_bank: RTL and testbench
===============================

IO_PORT_BANK -- requirements
Module: io_port_bank

Interface
REQ-001 Parameter BASE_ADDR, default 16'h8400: bank base address; 64-byte aligned.
REQ-002 Parameter WIDTH, default 8: bits per channel, legal 1..8.
REQ-003 Parameter CHANNELS, default 2: number of port channels, legal 1..8.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 addr  in  16  CPU address bus.
REQ-007 wr_data  in  8  CPU write data.
REQ-008 we  in  1  CPU write strobe, qualified by addr.
REQ-009 rd_data  out  8  registered read data.
REQ-010 rd_hit  out  1  registered flag: rd_data belongs to this bank, for the top-level read mux.
REQ-011 port_out  out  CHANNELS*WIDTH  output pins; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-012 port_in  in  CHANNELS*WIDTH  asynchronous input pins, same packing.
REQ-013 irq  out  1  level interrupt request.

Function
REQ-014 The decode window SHALL be BASE_ADDR .. BASE_ADDR+8*CHANNELS-1; channel c = (addr-BASE_ADDR)[5:3], register = addr[2:0].
REQ-015 Register offsets: 0 OUT (R/W), 1 OUT_SET (W1S, reads OUT), 2 OUT_CLR (W1C, reads OUT), 3 OUT_TGL (write-1 toggles, reads OUT), 4 IN (RO), 5 IRQ_MASK (R/W), 6 IRQ_STAT (R, W1C), 7 reserved (reads 0, writes ignored).
REQ-016 Writes SHALL take effect on the clk edge where we=1 and addr hits; only wr_data[WIDTH-1:0] is used.
REQ-017 Reads SHALL have 1-cycle latency: rd_data/rd_hit at cycle N+1 reflect addr at cycle N.
REQ-018 On a miss, rd_data SHALL be 8'h00 and rd_hit 0; bits above WIDTH SHALL read 0.
REQ-019 port_out SHALL be driven directly from the OUT registers with no extra delay.
REQ-020 port_in SHALL pass a 2-flop synchroniser per bit; IN reads the second stage, giving 2-cycle pin-to-register latency.
REQ-021 A write to IRQ_STAT SHALL NOT affect OUT; a read SHALL have no side effects.
REQ-022 A read-during-write to the same register SHALL return the pre-write value.

Reset
REQ-023 While reset_n=0: OUT, IRQ_MASK, IRQ_STAT, synchroniser stages, edge history, rd_data and rd_hit SHALL be 0, and irq SHALL be 0.
REQ-024 Assertion mid-operation SHALL clear state immediately; the first write accepted is on the first clk edge after reset_n rises.
REQ-025 After reset, edge history SHALL equal 0, so a pin held high produces one rising edge once synchronised.

Configuration
REQ-026 Macro IO_PORT_BANK_IRQ_EN: when defined, a rising edge of a synchronised IN bit (previous 0, current 1) SHALL set the matching IRQ_STAT bit, and irq = OR over all channels of (IRQ_STAT & IRQ_MASK).
REQ-027 If an edge and a W1C of the same IRQ_STAT bit coincide, the set SHALL win.
REQ-028 IRQ_STAT bits SHALL set regardless of IRQ_MASK; the mask gates irq only.
REQ-029 When IO_PORT_BANK_IRQ_EN is undefined: no edge logic, IRQ_MASK and IRQ_STAT read 0 and ignore writes, irq tied to 0.

Verification
REQ-030 Reset then write 8'hA5 to BASE+0 -> port_out[7:0]=8'hA5 next cycle; read BASE+0 -> rd_data=8'hA5, rd_hit=1 one cycle later.
REQ-031 OUT=8'hF0; write 8'h0F to +1, 8'h30 to +2, 8'h81 to +3 -> OUT sequence 8'hFF, 8'hCF, 8'h4E.
REQ-032 Drive port_in ch1 = 8'h3C; read BASE+12 -> 8'h3C; pin change visible at 2 cycles, not 1.
REQ-033 Read BASE+8*CHANNELS and BASE-1 -> rd_data=0, rd_hit=0; WIDTH=4 read of OUT=4'hF -> 8'h0F.
REQ-034 IRQ_EN: mask ch0 = 8'h01, raise pin 0 -> IRQ_STAT=8'h01 and irq=1; W1C 8'h01 in the same cycle as a new edge -> bit stays 1.
REQ-035 Pulse reset_n low during a write to OUT -> OUT=0 and irq=0 immediately, and the write is lost.

Source files
------------

// File: rtl/io_port_bank.sv
// io_port_bank: memory-mapped bank of CHANNELS general-purpose I/O ports.
// Each channel has 8 byte registers: OUT, OUT_SET, OUT_CLR, OUT_TGL, IN,
// IRQ_MASK, IRQ_STAT, and one reserved slot.
// Reads are registered, so data appears one cycle after the address.
// Input pins pass through a 2-flop synchroniser before IN can read them.
// Optional feature macro: IO_PORT_BANK_IRQ_EN. It enables rising-edge interrupt
// capture into IRQ_STAT and the irq output. Without it, IRQ_MASK and IRQ_STAT
// read 0 and irq is tied to 0.
module io_port_bank #(
   parameter logic [15:0] BASE_ADDR = 16'h8400,
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned CHANNELS  = 2
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [15:0]                  addr,
   input  logic [7:0]                   wr_data,
   input  logic                         we,
   output logic [7:0]                   rd_data,
   output logic                         rd_hit,
   output logic [CHANNELS*WIDTH-1:0]    port_out,
   input  logic [CHANNELS*WIDTH-1:0]    port_in,
   output logic                         irq
);

   typedef enum logic [2:0] {
      REG_OUT  = 3'd0,
      REG_SET  = 3'd1,
      REG_CLR  = 3'd2,
      REG_TGL  = 3'd3,
      REG_IN   = 3'd4,
      REG_MASK = 3'd5,
      REG_STAT = 3'd6,
      REG_RSVD = 3'd7
   } reg_e;

   typedef logic [CHANNELS-1:0][WIDTH-1:0] bank_t;

   logic [15:0]      offset;
   logic             hit;
   logic [2:0]       ch_sel;
   reg_e             reg_sel;
   logic [WIDTH-1:0] wd;
   logic [CHANNELS-1:0] ch_wr;

   bank_t out_q;
   bank_t sync1_q;
   bank_t sync2_q;
   bank_t mask_v;
   bank_t stat_v;
   logic [WIDTH-1:0] rd_val;

   // Addresses below BASE_ADDR wrap to a large offset and therefore miss.
   assign offset  = addr - BASE_ADDR;
   assign hit     = (offset < 16'(8 * CHANNELS));
   assign ch_sel  = offset[5:3];
   assign reg_sel = reg_e'(addr[2:0]);
   assign wd      = wr_data[WIDTH-1:0];

   // Per-channel write enable from the decoded address.
   always_comb begin
      ch_wr = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         ch_wr[c] = we && hit && (32'(ch_sel) == c);
      end
   end

   // OUT registers with direct, set, clear and toggle write modes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q <= '0;
      end else begin
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (ch_wr[c]) begin
               case (reg_sel)
                  REG_OUT: out_q[c] <= wd;
                  REG_SET: out_q[c] <= out_q[c] | wd;
                  REG_CLR: out_q[c] <= out_q[c] & ~wd;
                  REG_TGL: out_q[c] <= out_q[c] ^ wd;
                  default: ;
               endcase
            end
         end
      end
   end

   assign port_out = out_q;

   // Two-stage synchroniser for the asynchronous input pins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= port_in;
         sync2_q <= sync1_q;
      end
   end

`ifdef IO_PORT_BANK_IRQ_EN
   bank_t mask_q;
   bank_t stat_q;
   bank_t prev_q;
   bank_t rise;

   assign rise = sync2_q & ~prev_q;

   // Interrupt mask, edge history and sticky status bits.
   // An edge is ORed in after the W1C clear, so a coincident edge wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_q <= '0;
         stat_q <= '0;
         prev_q <= '0;
      end else begin
         prev_q <= sync2_q;
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (ch_wr[c] && (reg_sel == REG_MASK)) begin
               mask_q[c] <= wd;
            end
            stat_q[c] <= (stat_q[c] & ~((ch_wr[c] && (reg_sel == REG_STAT)) ? wd : '0))
                         | rise[c];
         end
      end
   end

   assign mask_v = mask_q;
   assign stat_v = stat_q;
   assign irq    = |(stat_q & mask_q);
`else
   assign mask_v = '0;
   assign stat_v = '0;
   assign irq    = 1'b0;
`endif

   // Read mux; it uses pre-write register values, so read-during-write returns old data.
   always_comb begin
      rd_val = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (hit && (32'(ch_sel) == c)) begin
            case (reg_sel)
               REG_OUT, REG_SET, REG_CLR, REG_TGL: rd_val = out_q[c];
               REG_IN:   rd_val = sync2_q[c];
               REG_MASK: rd_val = mask_v[c];
               REG_STAT: rd_val = stat_v[c];
               default:  rd_val = '0;
            endcase
         end
      end
   end

   // Registered read data and hit flag, one cycle after the address.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data <= '0;
         rd_hit  <= 1'b0;
      end else begin
         rd_data <= 8'(rd_val);
         rd_hit  <= hit;
      end
   end

endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank: directed self-checking bench for io_port_bank.
// It checks a default instance (WIDTH=8, CHANNELS=2) and a WIDTH=4 instance.
module tb_io_port_bank;

   localparam logic [15:0] BASE = 16'h8400;

   logic        clk;
   logic        reset_n;
   logic [15:0] addr;
   logic [7:0]  wr_data;
   logic        we;
   logic [7:0]  rd_data;
   logic        rd_hit;
   logic [15:0] port_out;
   logic [15:0] port_in;
   logic        irq;

   logic [15:0] addr4;
   logic [7:0]  wr_data4;
   logic        we4;
   logic [7:0]  rd_data4;
   logic        rd_hit4;
   logic [7:0]  port_out4;
   logic [7:0]  port_in4;
   logic        irq4;

   int checks = 0;
   int errors = 0;

   logic [7:0] rv;
   logic       rh;

   io_port_bank #(.BASE_ADDR(BASE), .WIDTH(8), .CHANNELS(2)) u_dut (
      .clk(clk), .reset_n(reset_n), .addr(addr), .wr_data(wr_data), .we(we),
      .rd_data(rd_data), .rd_hit(rd_hit), .port_out(port_out),
      .port_in(port_in), .irq(irq)
   );

   io_port_bank #(.BASE_ADDR(BASE), .WIDTH(4), .CHANNELS(2)) u_dut4 (
      .clk(clk), .reset_n(reset_n), .addr(addr4), .wr_data(wr_data4), .we(we4),
      .rd_data(rd_data4), .rd_hit(rd_hit4), .port_out(port_out4),
      .port_in(port_in4), .irq(irq4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      addr = a; wr_data = d; we = 1'b1;
      @(posedge clk); #1;
      we = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic h);
      @(negedge clk);
      addr = a; we = 1'b0;
      @(posedge clk); #1;
      d = rd_data; h = rd_hit;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; addr = '0; wr_data = '0; we = 1'b0; port_in = '0;
      addr4 = '0; wr_data4 = '0; we4 = 1'b0; port_in4 = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (port_out !== 16'h0000) begin errors++; $display("FAIL reset_port_out got %h exp %h", port_out, 16'h0000); end
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp %h", rd_data, 8'h00); end
      checks++; if (rd_hit !== 1'b0) begin errors++; $display("FAIL reset_rd_hit got %b exp 0", rd_hit); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
      checks++; if (port_out4 !== 8'h00) begin errors++; $display("FAIL reset_port_out4 got %h exp 00", port_out4); end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_write_read;
      bus_write(BASE, 8'hA5);
      checks++; if (port_out[7:0] !== 8'hA5) begin errors++; $display("FAIL wr_out got %h exp a5", port_out[7:0]); end
      bus_read(BASE, rv, rh);
      checks++; if (rv !== 8'hA5) begin errors++; $display("FAIL rd_out got %h exp a5", rv); end
      checks++; if (rh !== 1'b1) begin errors++; $display("FAIL rd_out_hit got %b exp 1", rh); end
      bus_write(BASE + 16'd8, 8'h5A);
      checks++; if (port_out !== 16'h5AA5) begin errors++; $display("FAIL wr_ch1 got %h exp 5aa5", port_out); end
   endtask

   task automatic test_set_clr_tgl;
      bus_write(BASE, 8'hF0);
      bus_write(BASE + 16'd1, 8'h0F);
      checks++; if (port_out[7:0] !== 8'hFF) begin errors++; $display("FAIL set got %h exp ff", port_out[7:0]); end
      bus_write(BASE + 16'd2, 8'h30);
      checks++; if (port_out[7:0] !== 8'hCF) begin errors++; $display("FAIL clr got %h exp cf", port_out[7:0]); end
      bus_write(BASE + 16'd3, 8'h81);
      checks++; if (port_out[7:0] !== 8'h4E) begin errors++; $display("FAIL tgl got %h exp 4e", port_out[7:0]); end
      bus_read(BASE + 16'd3, rv, rh);
      checks++; if (rv !== 8'h4E) begin errors++; $display("FAIL rd_tgl got %h exp 4e", rv); end
      checks++; if (port_out[15:8] !== 8'h5A) begin errors++; $display("FAIL ch1_untouched got %h exp 5a", port_out[15:8]); end
   endtask

   task automatic test_read_during_write;
      @(negedge clk);
      addr = BASE; wr_data = 8'h33; we = 1'b1;
      @(posedge clk); #1;
      we = 1'b0;
      checks++; if (rd_data !== 8'h4E) begin errors++; $display("FAIL rdw_old got %h exp 4e", rd_data); end
      checks++; if (port_out[7:0] !== 8'h33) begin errors++; $display("FAIL rdw_new got %h exp 33", port_out[7:0]); end
      bus_read(BASE, rv, rh);
      checks++; if (rv !== 8'h33) begin errors++; $display("FAIL rdw_after got %h exp 33", rv); end
   endtask

   task automatic test_miss;
      bus_read(BASE + 16'd16, rv, rh);
      checks++; if (rv !== 8'h00) begin errors++; $display("FAIL miss_hi_data got %h exp 00", rv); end
      checks++; if (rh !== 1'b0) begin errors++; $display("FAIL miss_hi_hit got %b exp 0", rh); end
      bus_read(BASE - 16'd1, rv, rh);
      checks++; if (rv !== 8'h00) begin errors++; $display("FAIL miss_lo_data got %h exp 00", rv); end
      checks++; if (rh !== 1'b0) begin errors++; $display("FAIL miss_lo_hit got %b exp 0", rh); end
      bus_write(BASE + 16'd7, 8'hFF);
      bus_write(BASE + 16'd16, 8'h99);
      checks++; if (port_out !== 16'h5A33) begin errors++; $display("FAIL ignored_writes got %h exp 5a33", port_out); end
      bus_read(BASE + 16'd7, rv, rh);
      checks++; if (rv !== 8'h00) begin errors++; $display("FAIL rsvd_data got %h exp 00", rv); end
      checks++; if (rh !== 1'b1) begin errors++; $display("FAIL rsvd_hit got %b exp 1", rh); end
   endtask

   task automatic test_width4;
      @(negedge clk);
      addr4 = BASE + 16'd8; wr_data4 = 8'hFF; we4 = 1'b1;
      @(posedge clk); #1;
      we4 = 1'b0;
      checks++; if (port_out4 !== 8'hF0) begin errors++; $display("FAIL w4_out got %h exp f0", port_out4); end
      @(negedge clk);
      addr4 = BASE + 16'd8;
      @(posedge clk); #1;
      checks++; if (rd_data4 !== 8'h0F) begin errors++; $display("FAIL w4_rd got %h exp 0f", rd_data4); end
      checks++; if (rd_hit4 !== 1'b1) begin errors++; $display("FAIL w4_hit got %b exp 1", rd_hit4); end
   endtask

   // The pin changes before edge 1, and IN holds it after edge 2.
   // A read captured at edge 2 still sees the old IN value.
   // A read captured at edge 3 sees the new value.
   task automatic test_input_sync;
      @(negedge clk);
      port_in = 16'h3C00; addr = BASE + 16'd12; we = 1'b0;
      @(posedge clk); #1;
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL sync_e1 got %h exp 00", rd_data); end
      @(posedge clk); #1;
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL sync_e2 got %h exp 00", rd_data); end
      @(posedge clk); #1;
      checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL sync_e3 got %h exp 3c", rd_data); end
      checks++; if (rd_hit !== 1'b1) begin errors++; $display("FAIL sync_hit got %b exp 1", rd_hit); end
   endtask

   task automatic test_irq;
`ifdef IO_PORT_BANK_IRQ_EN
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_unmasked got %b exp 0", irq); end
      bus_read(BASE + 16'd14, rv, rh);
      checks++; if (rv !== 8'h3C) begin errors++; $display("FAIL stat_nomask got %h exp 3c", rv); end
      bus_write(BASE + 16'd5, 8'h01);
      bus_read(BASE + 16'd5, rv, rh);
      checks++; if (rv !== 8'h01) begin errors++; $display("FAIL mask_rd got %h exp 01", rv); end
      @(negedge clk); port_in[0] = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq); end
      bus_read(BASE + 16'd6, rv, rh);
      checks++; if (rv !== 8'h01) begin errors++; $display("FAIL stat_set got %h exp 01", rv); end
      bus_write(BASE + 16'd6, 8'h01);
      bus_read(BASE + 16'd6, rv, rh);
      checks++; if (rv !== 8'h00) begin errors++; $display("FAIL stat_w1c got %h exp 00", rv); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr got %b exp 0", irq); end
      checks++; if (port_out !== 16'h5A33) begin errors++; $display("FAIL w1c_no_out got %h exp 5a33", port_out); end
      @(negedge clk); port_in[0] = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk); port_in[0] = 1'b1;
      @(posedge clk);
      @(posedge clk);
      bus_write(BASE + 16'd6, 8'h01);
      bus_read(BASE + 16'd6, rv, rh);
      checks++; if (rv !== 8'h01) begin errors++; $display("FAIL set_wins got %h exp 01", rv); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL set_wins_irq got %b exp 1", irq); end
`else
      bus_write(BASE + 16'd5, 8'hFF);
      bus_read(BASE + 16'd5, rv, rh);
      checks++; if (rv !== 8'h00) begin errors++; $display("FAIL mask_off got %h exp 00", rv); end
      bus_read(BASE + 16'd14, rv, rh);
      checks++; if (rv !== 8'h00) begin errors++; $display("FAIL stat_off got %h exp 00", rv); end
      @(negedge clk); port_in[0] = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_off got %b exp 0", irq); end
      checks++; if (port_out !== 16'h5A33) begin errors++; $display("FAIL off_no_out got %h exp 5a33", port_out); end
`endif
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      addr = BASE; wr_data = 8'h77; we = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      checks++; if (port_out !== 16'h0000) begin errors++; $display("FAIL rst_mid_out got %h exp 0000", port_out); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_mid_irq got %b exp 0", irq); end
      checks++; if (rd_hit !== 1'b0) begin errors++; $display("FAIL rst_mid_hit got %b exp 0", rd_hit); end
      @(posedge clk);
      @(negedge clk);
      we = 1'b0; reset_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (port_out !== 16'h0000) begin errors++; $display("FAIL rst_write_lost got %h exp 0000", port_out); end
      bus_write(BASE, 8'h11);
      checks++; if (port_out !== 16'h0011) begin errors++; $display("FAIL post_rst_write got %h exp 0011", port_out); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_set_clr_tgl();
      test_read_during_write();
      test_miss();
      test_width4();
      test_input_sync();
      test_irq();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
